// File: rtl/sevenseg_pkg.sv
// Shared code-field layout and FSM state types for the seven-segment scan controller.
package sevenseg_pkg;

    localparam int unsigned BLANK_BIT = 6;
    localparam int unsigned DP_BIT    = 5;
    localparam int unsigned DASH_BIT  = 4;

    localparam logic [6:0] CODE_BLANK = 7'b1000000;

    typedef enum logic {
        ScanShow,
        ScanGuard
    } scan_state_e;

    typedef enum logic {
        UpdEmpty,
        UpdFull
    } upd_state_e;

    // A plain "0" digit: no blank, no dp, no dash, value zero.
    function automatic logic code_is_zero(input logic [6:0] code);
        return !code[BLANK_BIT] && !code[DP_BIT] && !code[DASH_BIT] && (code[3:0] == 4'd0);
    endfunction

endpackage

// File: rtl/sevenseg_prescale.sv
// Free-running digit-interval prescaler: counts 0..DIV-1 while enabled, ticks on DIV-1.
module sevenseg_prescale #(
    parameter int unsigned DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned    CntW   = $clog2(DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (en) begin
            if (cnt_q == CntMax) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sevenseg_scan_ctl.sv
// Multiplexed seven-segment scan controller with double-buffered frame updates.
// Define SEVENSEG_LZB_EN to enable leading-zero blanking.
module sevenseg_scan_ctl
    import sevenseg_pkg::*;
#(
    parameter int unsigned NDIGITS = 8,
    parameter int unsigned DIV     = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    input  logic [7*NDIGITS-1:0]   wr_data,
    output logic                   wr_ready,
    output logic [6:0]             d,
    output logic [NDIGITS-1:0]     an_n
);

    localparam int unsigned IdxW = $clog2(NDIGITS);

    scan_state_e          scan_q, scan_d;
    upd_state_e           upd_q, upd_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [7*NDIGITS-1:0] shadow_q, shadow_d;
    logic [7*NDIGITS-1:0] pending_q, pending_d;
    logic [6:0]           d_q, d_d;
    logic [NDIGITS-1:0]   an_n_q, an_n_d;

    logic                 presc_en;
    logic                 tick;
    logic                 boundary;
    logic [6:0]           cur_code;
    logic [NDIGITS-1:0]   lzb_mask;
    logic                 lzb_sel;

    assign presc_en = (scan_q == ScanShow);

    sevenseg_prescale #(
        .DIV (DIV)
    ) u_prescale (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en),
        .tick (tick)
    );

    assign boundary = (scan_q == ScanGuard) && (idx_q == IdxW'(NDIGITS - 1));
    assign wr_ready = (upd_q == UpdEmpty);

    always_comb begin
        scan_d = scan_q;
        idx_d  = idx_q;
        case (scan_q)
            ScanShow: begin
                if (tick) scan_d = ScanGuard;
            end
            ScanGuard: begin
                scan_d = ScanShow;
                idx_d  = (idx_q == IdxW'(NDIGITS - 1)) ? '0 : idx_q + 1'b1;
            end
            default: scan_d = ScanShow;
        endcase
    end

    // Shadow only ever changes at the frame boundary, so a frame is never torn mid-scan.
    always_comb begin
        upd_d     = upd_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        case (upd_q)
            UpdEmpty: begin
                if (wr_valid) begin
                    pending_d = wr_data;
                    upd_d     = UpdFull;
                end
            end
            UpdFull: begin
                if (boundary) begin
                    shadow_d = pending_q;
                    upd_d    = UpdEmpty;
                end
            end
            default: upd_d = UpdEmpty;
        endcase
    end

    always_comb begin
        cur_code = CODE_BLANK;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx_q == IdxW'(i)) cur_code = shadow_q[7*i +: 7];
        end

        lzb_mask = '0;
`ifdef SEVENSEG_LZB_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int i = NDIGITS - 1; i >= 1; i--) begin
                lead        = lead && code_is_zero(shadow_q[7*i +: 7]);
                lzb_mask[i] = lead;
            end
        end
`else
        lzb_mask = '0;
`endif
        lzb_sel = lzb_mask[idx_q];

        an_n_d = '1;
        d_d    = CODE_BLANK;
        if (scan_q == ScanShow) begin
            an_n_d = ~(NDIGITS'(1) << idx_q);
            d_d    = (cur_code[BLANK_BIT] || lzb_sel) ? CODE_BLANK : cur_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q    <= ScanShow;
            upd_q     <= UpdEmpty;
            idx_q     <= '0;
            shadow_q  <= {NDIGITS{CODE_BLANK}};
            pending_q <= {NDIGITS{CODE_BLANK}};
            d_q       <= CODE_BLANK;
            an_n_q    <= '1;
        end else begin
            scan_q    <= scan_d;
            upd_q     <= upd_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            d_q       <= d_d;
            an_n_q    <= an_n_d;
        end
    end

    assign d    = d_q;
    assign an_n = an_n_q;

endmodule

// File: doc/sevenseg_scan_ctl.md
SEVENSEG_SCAN_CTL -- requirements
Module: sevenseg_scan_ctl

Interface
REQ-001 Parameter NDIGITS, default 8, number of multiplexed digits (2..8).
REQ-002 Parameter DIV, default 100000, number of clk cycles per digit SHOW interval (≥2).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wr_valid  input  1  a new display frame is offered on wr_data.
REQ-006 wr_data  input  7*NDIGITS  per-digit code; digit i is bits [7i+6:7i], with bit6=blank, bit5=dp, bit4=dash and bits3:0=value.
REQ-007 wr_ready  output  1  high when a frame can be accepted.
REQ-008 d  output  7  code for the active digit, in the same bit layout, to the downstream decoder.
REQ-009 an_n  output  NDIGITS  active-low digit enables, at most one bit low.

Function
REQ-010 A frame transfer shall occur on any clk edge with wr_valid && wr_ready, capturing wr_data into the pending buffer.
REQ-011 The update FSM shall have states EMPTY (wr_ready=1) and FULL (wr_ready=0); a transfer moves EMPTY->FULL.
REQ-012 At a frame boundary (GUARD cycle of digit NDIGITS-1), FULL shall copy pending into the shadow and move to EMPTY.
REQ-013 The shadow shall change only at frame boundaries; a transfer on the frame-boundary cycle while EMPTY shall remain pending until the next boundary.
REQ-014 The prescaler shall count 0..DIV-1 in SHOW and wrap to 0; the tick is count==DIV-1.
REQ-015 The scan FSM shall have states SHOW and GUARD; tick in SHOW->GUARD; GUARD lasts exactly 1 cycle, then ->SHOW with idx advanced.
REQ-016 idx shall advance 0,1,...,NDIGITS-1,0 (wrap), so one digit period = DIV+1 cycles.
REQ-017 In SHOW, the registered outputs shall be an_n = ~(1<<idx) and d = effective shadow code of digit idx, both valid 1 cycle after entering SHOW.
REQ-018 In GUARD, the outputs shall be an_n = all ones and d = 7'b1000000 (blank), for anti-ghosting.
REQ-019 Blank (bit6) shall take precedence: any digit with bit6=1 shall be output as 7'b1000000 regardless of dp/dash.
REQ-020 wr_valid while wr_ready=0 shall be ignored, with no state change.

Reset
REQ-021 While rst=1 on a clock edge, the block shall set: prescaler=0, idx=0, scan state SHOW, update state EMPTY, shadow and pending all 7'b1000000.
REQ-022 The first registered outputs after reset shall be an_n = all ones, d = 7'b1000000, wr_ready = 1.
REQ-023 rst mid-frame shall discard pending data and the shadow immediately, with no partial transfer.

Configuration
REQ-024 Macro SEVENSEG_LZB_EN shall enable leading-zero blanking.
REQ-025 With SEVENSEG_LZB_EN defined, digits NDIGITS-1 downward whose shadow code is exactly 7'b0000000 shall be output as 7'b1000000 until the first digit with a different code; digit 0 shall never be blanked this way.
REQ-026 Without SEVENSEG_LZB_EN, shadow codes shall be output unmodified, except for REQ-019.

Structure
REQ-027 Package sevenseg_pkg shall hold the code-field bit positions (BLANK_BIT=6, DP_BIT=5, DASH_BIT=4), the constant CODE_BLANK=7'b1000000, and the scan and update FSM state enums.
REQ-028 The prescaler shall be a separate sub-module, sevenseg_prescale (parameter DIV; ports clk, rst, en, tick).

Verification (bench NDIGITS=4, DIV=4)
REQ-029 Reset: rst high 3 cycles, then low -> an_n=4'b1111, d=7'h40 and wr_ready=1 on the first cycle; an_n sequence 1110,1101,1011,0111 with 4 SHOW cycles and 1 all-ones GUARD cycle between each, period 20 cycles.
REQ-030 Write {7'h03,7'h02,7'h01,7'h00} mid-frame -> wr_ready=0 until the digit-3 GUARD; the next frame shows d=00,01,02,03 on digits 0..3.
REQ-031 Second write while FULL -> ignored; the original frame is displayed; a retry after wr_ready rises is accepted.
REQ-032 Write at the frame-boundary cycle while EMPTY -> displayed one full frame (20 cycles) later, not immediately.
REQ-033 With SEVENSEG_LZB_EN, codes {00,00,05,00} (digit3..0) -> digits 3 and 2 show 7'h40, digit 1 shows 05, digit 0 shows 00; with all codes 00, only digit 0 shows 00; digit with code 7'h7F -> 7'h40.
REQ-034 rst asserted while FULL -> pending dropped, all digits blank, wr_ready=1 after reset.
